// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding, frame geometry and the
// parity function used by both the transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // odd=0: even parity over data+P, odd=1: odd parity over data+P
    function automatic logic uart_parity(
        input logic [UART_DATA_BITS-1:0] data,
        input logic                      odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts enabled cycles and fires a one-cycle tick every
// div_cnt_rate cycles; clear restarts the bit period from zero.
module uart_baud_tick #(
    parameter int unsigned             div_cnt_bit  = 32,
    parameter logic [div_cnt_bit-1:0]  div_cnt_rate = 1736
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    logic [div_cnt_bit-1:0] cnt_q;
    logic [div_cnt_bit-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == div_cnt_rate - 1'b1);

    // next count: clear wins, wrap on tick, otherwise advance when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_writer.sv
// Byte-wide UART transmitter: start, D0..D7, parity, stop on txd.
// UART_WRITER_SKID_EN adds a one-byte holding register for gapless frames.
module uart_writer
    import uart_pkg::*;
#(
    parameter int unsigned             div_cnt_bit  = 32,
    parameter logic [div_cnt_bit-1:0]  div_cnt_rate = 32'd1736,
    parameter logic                    parity_odd   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] d,
    output logic       ready,
    output logic       busy,
    output logic       txd
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        txd_q, txd_d;
    logic        rdy_en_q;
    logic        tick;
    logic        take;
    logic        launch;
    logic [7:0]  launch_data;

`ifdef UART_WRITER_SKID_EN
    logic        hold_vld_q, hold_vld_d;
    logic [7:0]  hold_q, hold_d;

    assign ready = rdy_en_q & ~hold_vld_q;
`else
    assign ready = rdy_en_q & ~busy;
`endif

    assign busy = (state_q != IDLE);
    assign take = valid & ready;
    assign txd  = txd_q;

    uart_baud_tick #(
        .div_cnt_bit  (div_cnt_bit),
        .div_cnt_rate (div_cnt_rate)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (launch),
        .en_i   (busy),
        .tick_o (tick)
    );

    // frame sequencing, byte launch and next line level
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        launch      = 1'b0;
        launch_data = d;
`ifdef UART_WRITER_SKID_EN
        hold_vld_d  = hold_vld_q;
        hold_d      = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                launch = take;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
`ifdef UART_WRITER_SKID_EN
                    // chain the next frame straight after the stop bit
                    if (hold_vld_q) begin
                        launch      = 1'b1;
                        launch_data = hold_q;
                        hold_vld_d  = 1'b0;
                    end else begin
                        launch = take;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_WRITER_SKID_EN
        if (take && !launch) begin
            hold_vld_d = 1'b1;
            hold_d     = d;
        end
`endif

        if (launch) begin
            state_d   = START;
            shift_d   = launch_data;
            par_d     = uart_parity(launch_data, parity_odd);
            bit_cnt_d = '0;
        end

        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    // state and datapath registers; reset idles the line high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            rdy_en_q  <= 1'b1;
        end
    end

`ifdef UART_WRITER_SKID_EN
    // holding register for a byte accepted mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_writer.sv
// Directed bench for uart_writer: even and odd parity instances, a txd
// receiver that decodes frames mid-bit and scores them against a queue.
module tb_uart_writer;

    localparam int RATE = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_w [2];
    logic [7:0] d_w     [2];
    logic       ready_w [2];
    logic       busy_w  [2];
    logic       txd_w   [2];

    int         ntot  = 0;
    int         npass = 0;
    int         cyc   = 0;
    int         acc_cyc;
    bit         abort0;

    logic [8:0] exp0 [$];
    logic [8:0] exp1 [$];
    int         st0  [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_writer #(
        .div_cnt_bit  (32),
        .div_cnt_rate (32'd16),
        .parity_odd   (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid_w[0]),
        .d     (d_w[0]),
        .ready (ready_w[0]),
        .busy  (busy_w[0]),
        .txd   (txd_w[0])
    );

    uart_writer #(
        .div_cnt_bit  (32),
        .div_cnt_rate (32'd16),
        .parity_odd   (1'b1)
    ) dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid_w[1]),
        .d     (d_w[1]),
        .ready (ready_w[1]),
        .busy  (busy_w[1]),
        .txd   (txd_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] expf(input logic [7:0] b,
                                        input logic odd);
        return {(^b) ^ odd, b};
    endfunction

    // drive a byte on instance k and hold valid until it is accepted
    task automatic send(input int k, input logic [7:0] b);
        int n = 0;
        valid_w[k] = 1'b1;
        d_w[k]     = b;
        while (ready_w[k] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 1000), 1);
        if (n < 1000) begin
            @(posedge clk);
            if (k == 0) exp0.push_back(expf(b, 1'b0));
            else        exp1.push_back(expf(b, 1'b1));
            #1;
            acc_cyc = cyc;
        end else begin
            valid_w[k] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((busy_w[k] !== 1'b0 || ready_w[k] !== 1'b1) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 5000), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // line receiver: find start bit, sample each bit at mid-period
    task automatic mon(input int k);
        logic [10:0] fr;
        logic [8:0]  e;
        bit          ab;
        bit          have;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && txd_w[k] === 1'b0) begin
                if (k == 0) st0.push_back(cyc);
                ab = 1'b0;
                fr = '1;
                for (int b = 0; b < 11; b++) begin
                    repeat ((b == 0) ? RATE / 2 : RATE) @(posedge clk);
                    #1;
                    if (k == 0 && abort0) begin
                        ab     = 1'b1;
                        abort0 = 1'b0;
                        break;
                    end
                    fr[b] = txd_w[k];
                end
                e    = '0;
                have = 1'b0;
                if (k == 0 && exp0.size() != 0) begin
                    e    = exp0.pop_front();
                    have = 1'b1;
                end else if (k == 1 && exp1.size() != 0) begin
                    e    = exp1.pop_front();
                    have = 1'b1;
                end
                if (!ab) begin
                    chk("frame_expected", 32'(have), 1);
                    chk("start_bit", 32'(fr[0]), 0);
                    chk("data_byte", 32'(fr[8:1]), 32'(e[7:0]));
                    chk("parity_bit", 32'(fr[9]), 32'(e[8]));
                    chk("stop_bit", 32'(fr[10]), 1);
                end
            end
        end
    endtask

    initial begin
        int  n;
        int  a1;
        int  a2;
        bit  lowok;

        rst_n      = 1'b0;
        valid_w[0] = 1'b0;
        valid_w[1] = 1'b0;
        d_w[0]     = '0;
        d_w[1]     = '0;
        abort0     = 1'b0;

        fork
            mon(0);
            mon(1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(txd_w[0]), 1);
        chk("rst_busy", 32'(busy_w[0]), 0);
        chk("rst_ready", 32'(ready_w[0]), 0);
        chk("rst_ready_odd", 32'(ready_w[1]), 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(ready_w[0]), 1);
        chk("ready_after_rst_odd", 32'(ready_w[1]), 1);

        // single frame, busy length
        @(negedge clk);
        send(0, 8'hA5);
        valid_w[0] = 1'b0;
        d_w[0]     = 8'h00;
        chk("busy_on", 32'(busy_w[0]), 1);
        chk("txd_start", 32'(txd_w[0]), 0);
        chk("ready_busy", 32'(ready_w[0]), 0);
        n = 0;
        while (busy_w[0] === 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_cycles", n, 176);
        chk("ready_after_frame", 32'(ready_w[0]), 1);
        chk("txd_idle", 32'(txd_w[0]), 1);

        // parity cases
        send(0, 8'h01);
        valid_w[0] = 1'b0;
        send(1, 8'h00);
        valid_w[1] = 1'b0;
        wait_idle(1);
        send(1, 8'hFF);
        valid_w[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);

        // valid held high across two bytes
        st0.delete();
        send(0, 8'h3C);
        a1 = acc_cyc;
        send(0, 8'hC3);
        a2 = acc_cyc;
        valid_w[0] = 1'b0;
        wait_idle(0);
        chk("b2b_frames", st0.size(), 2);
`ifdef UART_WRITER_SKID_EN
        chk("b2b_mid_accept", 32'((a2 - a1) < 176), 1);
        if (st0.size() == 2) chk("b2b_start_gap", st0[1] - st0[0], 176);
`else
        chk("b2b_accept_gap", a2 - a1, 177);
        if (st0.size() == 2) chk("b2b_start_gap", st0[1] - st0[0], 177);
`endif

`ifndef UART_WRITER_SKID_EN
        // valid pulse during a frame is dropped
        send(0, 8'h5A);
        valid_w[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        valid_w[0] = 1'b1;
        d_w[0]     = 8'hFF;
        chk("ready_drop", 32'(ready_w[0]), 0);
        @(posedge clk);
        #1;
        valid_w[0] = 1'b0;
        lowok = 1'b1;
        n = 0;
        while (busy_w[0] === 1'b1 && n < 400) begin
            if (ready_w[0] !== 1'b0) lowok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_low_busy", 32'(lowok), 1);
        wait_idle(0);
`endif

        // reset during data bit 4
        send(0, 8'h96);
        valid_w[0] = 1'b0;
        repeat (85) @(posedge clk);
        #2;
        abort0 = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("abort_txd", 32'(txd_w[0]), 1);
        chk("abort_busy", 32'(busy_w[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_flag_seen", 32'(abort0), 0);
        send(0, 8'h55);
        valid_w[0] = 1'b0;
        wait_idle(0);

        // all byte values
        for (int b = 0; b < 256; b++) begin
            send(0, 8'(b));
        end
        valid_w[0] = 1'b0;
        wait_idle(0);
        wait_idle(1);

        chk("sb_empty", exp0.size(), 0);
        chk("sb_empty_odd", exp1.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
